// File: rtl/rcu_packet_ctrl_if.sv
// rtl/rcu_packet_ctrl_if.sv - USB receive packet control bus bundle
// Purpose: groups the byte-stream inputs, FIFO write port and status outputs of rcu_packet_ctrl.
// Ports (modport slave = the control unit, master = upstream stage / FIFO / consumer):
//   d_edge, byte_received, rx_byte[7:0], eop_detected, fifo_full     -> into the control unit
//   rcving, pkt_type[1:0], rcv_pid[7:0], token_fields[15:0], w_enable,
//   rx_data[7:0], data_count, rcv_done, rcv_error, crc_ok            <- from the control unit
interface rcu_packet_ctrl_if #(
    parameter int MAX_DATA_BYTES = 8
);
    logic                                    d_edge;
    logic                                    byte_received;
    logic [7:0]                              rx_byte;
    logic                                    eop_detected;
    logic                                    fifo_full;
    logic                                    rcving;
    logic [1:0]                              pkt_type;
    logic [7:0]                              rcv_pid;
    logic [15:0]                             token_fields;
    logic                                    w_enable;
    logic [7:0]                              rx_data;
    logic [$clog2(MAX_DATA_BYTES+1)-1:0]     data_count;
    logic                                    rcv_done;
    logic                                    rcv_error;
    logic                                    crc_ok;

    modport slave (
        input  d_edge, byte_received, rx_byte, eop_detected, fifo_full,
        output rcving, pkt_type, rcv_pid, token_fields, w_enable, rx_data,
               data_count, rcv_done, rcv_error, crc_ok
    );

    modport master (
        output d_edge, byte_received, rx_byte, eop_detected, fifo_full,
        input  rcving, pkt_type, rcv_pid, token_fields, w_enable, rx_data,
               data_count, rcv_done, rcv_error, crc_ok
    );
endinterface

// File: rtl/rcu_packet_ctrl.sv
// rtl/rcu_packet_ctrl.sv - USB receive packet control unit (SYNC/PID/token/data/EOP parser)
// Purpose: parses decoded bytes into packets, writes payload to the RX FIFO with the two
//   trailing CRC16 bytes stripped, and reports packet type, completion and errors.
// Ports: clk, rst (synchronous, active-high), bus (rcu_packet_ctrl_if.slave).
// Optional feature: define RCU_CRC16_CHECK_EN to verify the CRC16 residual of data packets;
//   otherwise crc_ok is tied to 1 and the CRC bytes are dropped unchecked.
module rcu_packet_ctrl #(
    parameter int MAX_DATA_BYTES = 8
) (
    input  logic              clk,
    input  logic              rst,
    rcu_packet_ctrl_if.slave  bus
);
    localparam int         CW         = $clog2(MAX_DATA_BYTES + 1);
    localparam logic [7:0] SYNC_BYTE  = 8'b1000_0000;
    localparam logic [7:0] PID_TOKEN  = 8'b0001_1110;
    localparam logic [7:0] PID_DATA   = 8'b0011_1100;
    localparam logic [7:0] PID_HSHAKE = 8'b0010_1101;

    typedef enum logic [2:0] {
        IDLE, RCV_SYNC, RCV_PID, RCV_TOKEN, RCV_DATA, RCV_EOP, DONE, EIDLE
    } state_t;

    state_t     state;
    logic [7:0] hold_old;     // oldest byte of the 2-byte CRC-stripping buffer
    logic [7:0] hold_new;
    logic [1:0] held;         // bytes currently in the buffer (saturates at 2)
    logic       tok_second;   // next token byte is the second one
    logic       pid_ok;
    logic       at_max;
    logic       crc_bad;
    logic       err_evt;

    assign pid_ok = (bus.rx_byte[7:4] == ~bus.rx_byte[3:0]) &&
                    ((bus.rx_byte == PID_TOKEN) || (bus.rx_byte == PID_DATA) ||
                     (bus.rx_byte == PID_HSHAKE));
    assign at_max = (bus.data_count == CW'(MAX_DATA_BYTES));

`ifdef RCU_CRC16_CHECK_EN
    logic [15:0] crc;

    // Reflected CRC16 (poly 0xA001), data folded LSB first.
    function automatic logic [15:0] crc_fold(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            if (r[0] ^ d[i]) r = (r >> 1) ^ 16'hA001;
            else             r = r >> 1;
        end
        return r;
    endfunction

    // Payload plus appended CRC leaves this fixed residual when intact.
    assign crc_bad = (crc != 16'hB001);

    always_ff @(posedge clk) begin
        if (rst) begin
            crc        <= 16'hFFFF;
            bus.crc_ok <= 1'b1;
        end else if (state == RCV_PID && bus.byte_received && pid_ok &&
                     bus.rx_byte == PID_DATA) begin
            crc <= 16'hFFFF;
        end else if (state == RCV_DATA) begin
            if (bus.byte_received && !bus.eop_detected)
                crc <= crc_fold(crc, bus.rx_byte);
            else if (bus.eop_detected && !bus.byte_received && held == 2'd2)
                bus.crc_ok <= !crc_bad;
        end
    end
`else
    assign crc_bad    = 1'b0;
    assign bus.crc_ok = 1'b1;
`endif

    // Every condition that aborts the packet into EIDLE, per state.
    always_comb begin
        err_evt = 1'b0;
        case (state)
            RCV_SYNC:  err_evt = bus.eop_detected ||
                                 (bus.byte_received && bus.rx_byte != SYNC_BYTE);
            RCV_PID:   err_evt = bus.eop_detected || (bus.byte_received && !pid_ok);
            RCV_TOKEN: err_evt = bus.eop_detected;
            RCV_DATA:  err_evt = (bus.eop_detected && (held != 2'd2 || crc_bad)) ||
                                 (bus.byte_received && held == 2'd2 &&
                                  (bus.fifo_full || at_max));
            RCV_EOP:   err_evt = bus.byte_received;
            default:   err_evt = 1'b0;
        endcase
        // Byte and EOP together means the EOP was not byte-aligned.
        if (bus.byte_received && bus.eop_detected && state != IDLE && state != EIDLE)
            err_evt = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            hold_old         <= 8'h00;
            hold_new         <= 8'h00;
            held             <= 2'd0;
            tok_second       <= 1'b0;
            bus.rcving       <= 1'b0;
            bus.pkt_type     <= 2'b00;
            bus.rcv_pid      <= 8'h00;
            bus.token_fields <= 16'h0000;
            bus.w_enable     <= 1'b0;
            bus.rx_data      <= 8'h00;
            bus.data_count   <= '0;
            bus.rcv_done     <= 1'b0;
            bus.rcv_error    <= 1'b0;
        end else begin
            bus.w_enable <= 1'b0;
            bus.rcv_done <= 1'b0;
            if (err_evt) begin
                state         <= EIDLE;
                bus.rcving    <= 1'b0;
                bus.rcv_error <= 1'b1;
            end else begin
                case (state)
                    IDLE: if (bus.d_edge) begin
                        state          <= RCV_SYNC;
                        bus.rcving     <= 1'b1;
                        bus.rcv_error  <= 1'b0;
                        bus.data_count <= '0;
                        held           <= 2'd0;
                        tok_second     <= 1'b0;
                    end
                    RCV_SYNC: if (bus.byte_received) state <= RCV_PID;
                    RCV_PID: if (bus.byte_received) begin
                        bus.rcv_pid <= bus.rx_byte;
                        if (bus.rx_byte == PID_TOKEN) begin
                            bus.pkt_type <= 2'b01;
                            state        <= RCV_TOKEN;
                        end else if (bus.rx_byte == PID_DATA) begin
                            bus.pkt_type <= 2'b10;
                            state        <= RCV_DATA;
                        end else begin
                            bus.pkt_type <= 2'b11;
                            state        <= RCV_EOP;
                        end
                    end
                    RCV_TOKEN: if (bus.byte_received) begin
                        if (!tok_second) begin
                            bus.token_fields[7:0] <= bus.rx_byte;
                            tok_second            <= 1'b1;
                        end else begin
                            bus.token_fields[15:8] <= bus.rx_byte;
                            state                  <= RCV_EOP;
                        end
                    end
                    RCV_DATA: begin
                        if (bus.eop_detected) begin
                            // Buffer now holds the CRC16; it is dropped.
                            state        <= DONE;
                            bus.rcving   <= 1'b0;
                            bus.rcv_done <= 1'b1;
                        end else if (bus.byte_received) begin
                            if (held == 2'd2) begin
                                bus.w_enable   <= 1'b1;
                                bus.rx_data    <= hold_old;
                                bus.data_count <= bus.data_count + CW'(1);
                            end else begin
                                held <= held + 2'd1;
                            end
                            hold_old <= hold_new;
                            hold_new <= bus.rx_byte;
                        end
                    end
                    RCV_EOP: if (bus.eop_detected) begin
                        state        <= DONE;
                        bus.rcving   <= 1'b0;
                        bus.rcv_done <= 1'b1;
                    end
                    DONE:  state <= IDLE;
                    EIDLE: if (bus.eop_detected) state <= IDLE;
                    default: state <= EIDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_rcu_packet_ctrl.sv
// tb/tb_rcu_packet_ctrl.sv - directed self-checking bench for rcu_packet_ctrl
module tb_rcu_packet_ctrl;
    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad = 0;
    int   wr_total = 0;
    int   done_total = 0;
    logic [7:0] wr_log [0:255];
    logic [7:0] payload [0:15];
    int   wbase;
    int   dbase;

    always #5 clk = ~clk;

    rcu_packet_ctrl_if bus ();
    rcu_packet_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

    always @(negedge clk) begin
        if (bus.w_enable === 1'b1) begin
            wr_log[wr_total[7:0]] <= bus.rx_data;
            wr_total <= wr_total + 1;
        end
        if (bus.rcv_done === 1'b1) done_total <= done_total + 1;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_dedge;
        bus.d_edge = 1'b1;
        tick();
        bus.d_edge = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.byte_received = 1'b1;
        bus.rx_byte = b;
        tick();
        bus.byte_received = 1'b0;
        repeat (7) tick();
    endtask

    task automatic send_eop;
        bus.eop_detected = 1'b1;
        tick();
        bus.eop_detected = 1'b0;
    endtask

    function automatic logic [15:0] usb_crc16(input int n);
        logic [15:0] c;
        c = 16'hFFFF;
        for (int i = 0; i < n; i++)
            for (int k = 0; k < 8; k++)
                if (c[0] ^ payload[i][k]) c = (c >> 1) ^ 16'hA001;
                else                      c = c >> 1;
        return ~c;
    endfunction

    // d_edge, SYNC, DATA PID, n payload bytes, CRC16 low/high (optionally corrupted); no EOP.
    task automatic send_data_pkt(input int n, input logic flip);
        logic [15:0] c;
        c = usb_crc16(n);
        if (flip) c[0] = ~c[0];
        pulse_dedge();
        send_byte(8'h80);
        send_byte(8'h3C);
        for (int i = 0; i < n; i++) send_byte(payload[i]);
        send_byte(c[7:0]);
        send_byte(c[15:8]);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        total++; if (bus.rcving !== 1'b0) begin bad++; $display("FAIL reset_rcving got=%0h exp=0", bus.rcving); end
        total++; if (bus.pkt_type !== 2'b00) begin bad++; $display("FAIL reset_pkt_type got=%0h exp=0", bus.pkt_type); end
        total++; if (bus.token_fields !== 16'h0) begin bad++; $display("FAIL reset_token got=%0h exp=0", bus.token_fields); end
        total++; if (bus.w_enable !== 1'b0 || bus.rcv_done !== 1'b0 || bus.rcv_error !== 1'b0) begin bad++; $display("FAIL reset_strobes got=%0b%0b%0b exp=000", bus.w_enable, bus.rcv_done, bus.rcv_error); end
        total++; if (bus.data_count !== 4'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", bus.data_count); end
        total++; if (bus.crc_ok !== 1'b1) begin bad++; $display("FAIL reset_crc_ok got=%0h exp=1", bus.crc_ok); end
    endtask

    task automatic test_token;
        wbase = wr_total; dbase = done_total;
        pulse_dedge();
        total++; if (bus.rcving !== 1'b1) begin bad++; $display("FAIL token_rcving got=%0h exp=1", bus.rcving); end
        send_byte(8'h80); send_byte(8'h1E); send_byte(8'hA5); send_byte(8'h3C);
        send_eop();
        total++; if (bus.rcv_done !== 1'b1) begin bad++; $display("FAIL token_done_latency got=%0h exp=1", bus.rcv_done); end
        tick();
        total++; if (bus.rcv_done !== 1'b0) begin bad++; $display("FAIL token_done_width got=%0h exp=0", bus.rcv_done); end
        total++; if (bus.pkt_type !== 2'b01) begin bad++; $display("FAIL token_type got=%0h exp=1", bus.pkt_type); end
        total++; if (bus.token_fields !== 16'h3CA5) begin bad++; $display("FAIL token_fields got=%0h exp=3ca5", bus.token_fields); end
        total++; if (wr_total - wbase !== 0) begin bad++; $display("FAIL token_writes got=%0d exp=0", wr_total - wbase); end
        total++; if (done_total - dbase !== 1) begin bad++; $display("FAIL token_done_count got=%0d exp=1", done_total - dbase); end
    endtask

    task automatic test_data;
        wbase = wr_total; dbase = done_total;
        payload[0] = 8'h11; payload[1] = 8'h22; payload[2] = 8'h33;
        send_data_pkt(3, 1'b0);
        send_eop();
        total++; if (bus.rcv_done !== 1'b1) begin bad++; $display("FAIL data_done got=%0h exp=1", bus.rcv_done); end
        tick();
        total++; if (wr_total - wbase !== 3) begin bad++; $display("FAIL data_writes got=%0d exp=3", wr_total - wbase); end
        total++; if ({wr_log[wbase], wr_log[wbase+1], wr_log[wbase+2]} !== 24'h112233) begin bad++; $display("FAIL data_bytes got=%0h exp=112233", {wr_log[wbase], wr_log[wbase+1], wr_log[wbase+2]}); end
        total++; if (bus.data_count !== 4'd3) begin bad++; $display("FAIL data_count got=%0d exp=3", bus.data_count); end
        total++; if (bus.pkt_type !== 2'b10 || bus.rcv_pid !== 8'h3C) begin bad++; $display("FAIL data_pid got=%0h/%0h exp=2/3c", bus.pkt_type, bus.rcv_pid); end
        total++; if (bus.rcv_error !== 1'b0) begin bad++; $display("FAIL data_error got=%0h exp=0", bus.rcv_error); end
    endtask

    task automatic test_zero_payload;
        wbase = wr_total; dbase = done_total;
        send_data_pkt(0, 1'b0);
        send_eop();
        tick();
        total++; if (done_total - dbase !== 1 || wr_total - wbase !== 0) begin bad++; $display("FAIL zero_payload got=done%0d/wr%0d exp=done1/wr0", done_total - dbase, wr_total - wbase); end
        total++; if (bus.data_count !== 4'd0) begin bad++; $display("FAIL zero_count got=%0d exp=0", bus.data_count); end
    endtask

    task automatic test_handshake;
        dbase = done_total;
        pulse_dedge(); send_byte(8'h80); send_byte(8'h2D); send_eop(); tick();
        total++; if (bus.pkt_type !== 2'b11 || bus.rcv_pid !== 8'h2D) begin bad++; $display("FAIL hs_pid got=%0h/%0h exp=3/2d", bus.pkt_type, bus.rcv_pid); end
        total++; if (done_total - dbase !== 1) begin bad++; $display("FAIL hs_done got=%0d exp=1", done_total - dbase); end
        dbase = done_total;
        pulse_dedge(); send_byte(8'h80); send_byte(8'h2D); send_byte(8'h55);
        total++; if (bus.rcv_error !== 1'b1 || bus.rcving !== 1'b0) begin bad++; $display("FAIL hs_extra_error got=%0h/%0h exp=1/0", bus.rcv_error, bus.rcving); end
        send_eop(); tick();
        total++; if (done_total - dbase !== 0) begin bad++; $display("FAIL hs_extra_done got=%0d exp=0", done_total - dbase); end
        total++; if (bus.rcv_error !== 1'b1) begin bad++; $display("FAIL hs_error_sticky got=%0h exp=1", bus.rcv_error); end
    endtask

    task automatic test_bad_sync;
        pulse_dedge();
        send_byte(8'h81);
        total++; if (bus.rcv_error !== 1'b1 || bus.rcving !== 1'b0) begin bad++; $display("FAIL sync_error got=%0h/%0h exp=1/0", bus.rcv_error, bus.rcving); end
        pulse_dedge();
        total++; if (bus.rcving !== 1'b0) begin bad++; $display("FAIL sync_eidle_hold got=%0h exp=0", bus.rcving); end
        send_eop(); tick();
        pulse_dedge();
        total++; if (bus.rcving !== 1'b1 || bus.rcv_error !== 1'b0) begin bad++; $display("FAIL sync_recover got=%0h/%0h exp=1/0", bus.rcving, bus.rcv_error); end
        send_byte(8'h80);
        send_byte(8'h1F);
        total++; if (bus.rcv_error !== 1'b1) begin bad++; $display("FAIL pid_error got=%0h exp=1", bus.rcv_error); end
        send_eop(); tick();
    endtask

    task automatic test_overflow;
        wbase = wr_total; dbase = done_total;
        for (int i = 0; i < 9; i++) payload[i] = 8'(i + 1);
        send_data_pkt(9, 1'b0);
        total++; if (wr_total - wbase !== 8) begin bad++; $display("FAIL ovf_writes got=%0d exp=8", wr_total - wbase); end
        total++; if (wr_log[wbase+7] !== 8'h08 || bus.data_count !== 4'd8) begin bad++; $display("FAIL ovf_last got=%0h/%0d exp=08/8", wr_log[wbase+7], bus.data_count); end
        total++; if (bus.rcv_error !== 1'b1) begin bad++; $display("FAIL ovf_error got=%0h exp=1", bus.rcv_error); end
        send_eop(); tick();
        total++; if (done_total - dbase !== 0) begin bad++; $display("FAIL ovf_done got=%0d exp=0", done_total - dbase); end
    endtask

    task automatic test_fifo_full;
        wbase = wr_total;
        bus.fifo_full = 1'b1;
        pulse_dedge();
        send_byte(8'h80); send_byte(8'h3C); send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
        bus.fifo_full = 1'b0;
        total++; if (wr_total - wbase !== 0 || bus.rcv_error !== 1'b1) begin bad++; $display("FAIL full_suppress got=wr%0d/err%0h exp=wr0/err1", wr_total - wbase, bus.rcv_error); end
        send_eop(); tick();
    endtask

    task automatic test_nonaligned_eop;
        dbase = done_total;
        pulse_dedge();
        send_byte(8'h80); send_byte(8'h3C); send_byte(8'h11);
        bus.byte_received = 1'b1; bus.rx_byte = 8'h22; bus.eop_detected = 1'b1;
        tick();
        bus.byte_received = 1'b0; bus.eop_detected = 1'b0;
        total++; if (bus.rcv_error !== 1'b1 || bus.rcving !== 1'b0) begin bad++; $display("FAIL nonaligned got=%0h/%0h exp=1/0", bus.rcv_error, bus.rcving); end
        send_eop(); tick();
        total++; if (done_total - dbase !== 0) begin bad++; $display("FAIL nonaligned_done got=%0d exp=0", done_total - dbase); end
    endtask

    task automatic test_reset_mid;
        wbase = wr_total;
        pulse_dedge();
        send_byte(8'h80); send_byte(8'h3C); send_byte(8'h11); send_byte(8'h22);
        rst = 1'b1; tick(); rst = 1'b0;
        total++; if (bus.rcving !== 1'b0 || bus.data_count !== 4'd0) begin bad++; $display("FAIL rstmid_state got=%0h/%0d exp=0/0", bus.rcving, bus.data_count); end
        send_byte(8'h33);
        total++; if (wr_total - wbase !== 0) begin bad++; $display("FAIL rstmid_writes got=%0d exp=0", wr_total - wbase); end
        dbase = done_total;
        payload[0] = 8'h44;
        send_data_pkt(1, 1'b0);
        send_eop(); tick();
        total++; if (wr_total - wbase !== 1 || wr_log[wbase] !== 8'h44 || done_total - dbase !== 1) begin bad++; $display("FAIL rstmid_clean got=wr%0d/%0h/done%0d exp=wr1/44/done1", wr_total - wbase, wr_log[wbase], done_total - dbase); end
    endtask

    task automatic test_crc;
        payload[0] = 8'h01; payload[1] = 8'h02;
        dbase = done_total;
        send_data_pkt(2, 1'b0);
        send_eop(); tick();
        total++; if (bus.crc_ok !== 1'b1 || done_total - dbase !== 1) begin bad++; $display("FAIL crc_good got=ok%0h/done%0d exp=ok1/done1", bus.crc_ok, done_total - dbase); end
        dbase = done_total;
        send_data_pkt(2, 1'b1);
        send_eop(); tick();
`ifdef RCU_CRC16_CHECK_EN
        total++; if (bus.crc_ok !== 1'b0 || bus.rcv_error !== 1'b1 || done_total - dbase !== 0) begin bad++; $display("FAIL crc_bad got=ok%0h/err%0h/done%0d exp=ok0/err1/done0", bus.crc_ok, bus.rcv_error, done_total - dbase); end
        send_eop(); tick();
`else
        total++; if (bus.crc_ok !== 1'b1 || done_total - dbase !== 1) begin bad++; $display("FAIL crc_unchecked got=ok%0h/done%0d exp=ok1/done1", bus.crc_ok, done_total - dbase); end
`endif
    endtask

    initial begin
        rst = 1'b1;
        bus.d_edge = 1'b0; bus.byte_received = 1'b0; bus.rx_byte = 8'h00;
        bus.eop_detected = 1'b0; bus.fifo_full = 1'b0;
        test_reset();
        test_token();
        test_data();
        test_zero_payload();
        test_handshake();
        test_bad_sync();
        test_overflow();
        test_fifo_full();
        test_nonaligned_eop();
        test_reset_mid();
        test_crc();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
